fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the single write port of the 16-deep, 6-bit tile FIFO between `N_REQ` producers. Each producer raises a request and presents a word. The arbiter grants one producer at a time for a bounded burst of up to `MAX_BURST` words and drives the FIFO write strobe and data. It respects the FIFO `full` flag and returns a per-word acknowledge to the granted producer. It sits between the producer blocks and the FIFO write side; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the tile FIFO write port
// Grants one producer for up to MAX_BURST words, honouring fifo_full and ena.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 6,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_wdata,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(MAX_BURST - 1);
  localparam logic [PW-1:0] OWNER_LAST = PW'(N_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   burst_cnt;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   scan_idx;
  logic            sel_valid;
  logic            owner_req;
  logic            wr;
  logic [DW-1:0]   owner_data;

  // gnt is one-hot on owner, so masking with it selects the owner's request/data.
  assign owner_req  = |(req & gnt);
  assign wr         = busy & ena & owner_req & ~fifo_full;
  assign fifo_wr_en = wr;
  assign ack        = wr ? gnt : '0;
  assign fifo_wdata = wr ? owner_data : '0;

  always_comb begin
    owner_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      owner_data = owner_data | (wdata[k*DW +: DW] & {DW{gnt[k]}});
    end
  end

  // Scan from the far end back toward ptr so the nearest requester wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_idx = PW'((int'(ptr) + i) % N_REQ);
      if (req[scan_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state     <= BURST;
            owner     <= sel_idx;
            gnt       <= N_REQ'(1) << sel_idx;
            burst_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        BURST: begin
          if (!owner_req || (wr && burst_cnt == CNT_LAST)) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
            ptr       <= (owner == OWNER_LAST) ? '0 : owner + 1'b1;
          end else if (wr) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
// Behavioural grant/burst model compared every cycle, plus directed literal checks.
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 6, MAXB = 4;

  logic clk = 1'b0;
  logic rst, ena, fifo_full;
  logic [N-1:0] req, gnt, ack;
  logic [N*DW-1:0] wdata;
  logic fifo_wr_en, busy;
  logic [DW-1:0] fifo_wdata;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata), .busy(busy)
  );

  int total = 0, bad = 0, cyc = 0;
  bit chk_on, auto_full;
  int m_busy, m_owner, m_ptr, m_cnt;
  logic [DW-1:0] pdata [N];
  int lw[$], lo[$], lc[$];
  logic [DW-1:0] fq[$];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive, compare against the model, then advance the model at the edge.
  task automatic step();
    logic [N-1:0] e_gnt, e_ack;
    logic e_wr;
    logic [DW-1:0] e_dat;
    int ow;
    bit found;
    for (int k = 0; k < N; k++) wdata[k*DW +: DW] = pdata[k];
    if (auto_full) fifo_full = (fq.size() >= 15);
    #1;
    e_gnt = m_busy ? (N'(1) << m_owner) : '0;
    e_wr  = (m_busy != 0) && ena && req[m_owner] && !fifo_full;
    e_ack = e_wr ? e_gnt : '0;
    e_dat = e_wr ? wdata[m_owner*DW +: DW] : '0;
    if (chk_on) begin
      check("gnt", gnt, e_gnt);
      check("busy", busy, m_busy);
      check("wr_en", fifo_wr_en, e_wr);
      check("ack", ack, e_ack);
      check("wdata", fifo_wdata, e_dat);
    end
    @(posedge clk);
    ow = m_owner;
    if (e_wr) pdata[ow] = pdata[ow] + 1'b1;
    if (e_wr && !rst) begin
      lw.push_back(e_dat); lo.push_back(ow); lc.push_back(cyc);
      fq.push_back(e_dat);
    end
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (ena) begin
      if (m_busy == 0) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          if (!found && req[(m_ptr + i) % N]) begin
            found = 1; m_owner = (m_ptr + i) % N; m_busy = 1; m_cnt = 0;
          end
        end
      end else if (!req[m_owner] || (e_wr && m_cnt + 1 == MAXB)) begin
        m_busy = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
      end else if (e_wr) begin
        m_cnt++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; req = '0; ena = 1; fifo_full = 0; auto_full = 0;
    step();
    rst = 0; cyc = 0;
    lw.delete(); lo.delete(); lc.delete(); fq.delete();
    for (int k = 0; k < N; k++) pdata[k] = '0;
  endtask

  initial begin
    rst = 1; ena = 1; req = '1; fifo_full = 0; auto_full = 0; chk_on = 0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    for (int k = 0; k < N; k++) pdata[k] = '0;

    // Reset with every request high
    step();
    chk_on = 1;
    step();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_wr", fifo_wr_en, 0);
    rst = 0;
    step();
    check("first_gnt", gnt, 4'b0001);

    // Burst limit: requester 2 alone, words 1..6
    do_reset();
    pdata[2] = 6'h01; req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 4) begin
        check("bl_ptr1", dut.ptr, 3);
        check("bl_idle_gnt", gnt, 0);
      end
    end
    req = '0;
    step();
    check("bl_ptr2", dut.ptr, 3);
    check("bl_nwr", lw.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("bl_word", lw[i], i + 1);
      check("bl_cyc", lc[i], (i < 4) ? i + 1 : i + 2);
    end

    // Round-robin with FIFO filling to 15 entries
    do_reset();
    for (int k = 0; k < N; k++) pdata[k] = 6'(k << 4);
    req = '1; auto_full = 1;
    for (int c = 0; c < 20; c++) step();
    check("rr_fill", fq.size(), 15);
    for (int i = 0; i < 15; i++) check("rr_order", fq[i], ((i / 4) << 4) | (i % 4));
    check("rr_stall_gnt", gnt, 4'b1000);
    check("rr_stall_wr", fifo_wr_en, 0);
    fq.delete();
    for (int c = 0; c < 6; c++) step();
    check("rr_16th", lw[15], 6'h33);
    check("rr_wrap_owner", lo[16], 0);
    check("rr_wrap_cyc", lc[16], 22);
    check("rr_wrap_word", lw[16], 6'h04);
    auto_full = 0;

    // Full stall mid-burst for requester 1
    do_reset();
    pdata[1] = 6'h08; req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      step();
      if (c == 4) begin
        check("fs_cnt", dut.burst_cnt, 2);
        check("fs_gnt", gnt, 4'b0010);
        check("fs_ack", ack, 0);
      end
    end
    fifo_full = 0;
    for (int i = 0; i < 4; i++) begin
      check("fs_word", lw[i], 8 + i);
      check("fs_cyc", lc[i], (i < 2) ? i + 1 : i + 4);
    end

    // Early drop by requester 3, requester 0 pending
    do_reset();
    req = 4'b1000; step();
    req = 4'b1001; step(); step();
    req = 4'b0001; step();
    check("ed_ptr", dut.ptr, 0);
    check("ed_gnt_idle", gnt, 0);
    step();
    check("ed_gnt0", gnt, 4'b0001);
    check("ed_acks", lw.size(), 2);

    // Enable gating then mid-burst reset
    do_reset();
    pdata[2] = 6'h20; req = 4'b0100;
    step(); step(); step();
    ena = 0;
    step(); step();
    check("en_cnt", dut.burst_cnt, 2);
    check("en_gnt", gnt, 4'b0100);
    check("en_busy", busy, 1);
    check("en_wr", fifo_wr_en, 0);
    ena = 1;
    step();
    rst = 1;
    step();
    rst = 0;
    check("mr_gnt", gnt, 0);
    check("mr_busy", busy, 0);
    check("mr_ptr", dut.ptr, 0);
    check("mr_writes", lw.size(), 3);

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      ena = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < N; k++) if ($urandom_range(0, 5) == 0) req[k] = ~req[k];
      fifo_full = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
